// File: rtl/fpu_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// fpu_dispatch_pkg : opcode, instruction-field and FSM state definitions
//                    shared by the dispatch unit and coprocessor decode
// Revision : 1.0
// ============================================================================
package fpu_dispatch_pkg;

    localparam logic [5:0] OPC_NOP   = 6'b000000;
    localparam logic [5:0] OPC_ADD   = 6'b110000;
    localparam logic [5:0] OPC_SUB   = 6'b110001;
    localparam logic [5:0] OPC_MUL   = 6'b110010;
    localparam logic [5:0] OPC_DIV   = 6'b110011;
    localparam logic [5:0] OPC_CMP   = 6'b110100;
    localparam logic [5:0] OPC_REV   = 6'b110101;
    localparam logic [5:0] OPC_RND   = 6'b110110;
    localparam logic [5:0] OPC_LOAD  = 6'b001010;
    localparam logic [5:0] OPC_STORE = 6'b001011;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_LD_WAIT  = 3'd2,
        S_LD_WR    = 3'd3,
        S_ST_ISSUE = 3'd4,
        S_ST_CAP   = 3'd5,
        S_ST_HOLD  = 3'd6
    } fsm_state_e;

    // Arithmetic opcodes occupy the contiguous range ADD..RND.
    function automatic logic is_arith(input logic [5:0] opc);
        return (opc >= OPC_ADD) && (opc <= OPC_RND);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_inst_fifo.sv
`default_nettype none
// ============================================================================
// fpu_inst_fifo : parameterized synchronous FIFO, asynchronous reset
// Revision : 1.0
// ============================================================================
module fpu_inst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra wrap bit on each pointer distinguishes full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/fpu_dispatch.sv
`default_nettype none
// ============================================================================
// fpu_dispatch : buffers FP instructions, decodes them and sequences issue,
//                load write-back and store read-out to the coprocessor
// Revision : 1.0
// ============================================================================
module fpu_dispatch
    import fpu_dispatch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] inst,
    input  logic        mem_stall,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    output logic        st_valid,
    input  logic        st_ready,
    output logic [31:0] st_data,
    output logic [5:0]  cop_opcode,
    output logic [4:0]  cop_in1,
    output logic [4:0]  cop_in2,
    output logic [4:0]  cop_dst,
    output logic [4:0]  cop_waddr,
    output logic [31:0] cop_wdata,
    output logic        cop_we,
    output logic        cop_cache_done,
    input  logic [31:0] cop_outdata,
    output logic        illegal_op,
    output logic [15:0] issued_cnt
);

    logic [31:0] head;
    logic        fifo_full, fifo_empty, push, pop, hold;
    logic [5:0]  head_opc;
    logic [4:0]  head_rs, head_rt, head_rd;
    logic        unused_head_bits;

    fsm_state_e  state_q, state_d;
    logic [5:0]  cop_opcode_q, cop_opcode_d;
    logic [4:0]  cop_in1_q, cop_in1_d, cop_in2_q, cop_in2_d, cop_dst_q, cop_dst_d;
    logic [4:0]  cop_waddr_q, cop_waddr_d, ld_rt_q, ld_rt_d;
    logic [31:0] cop_wdata_q, cop_wdata_d, st_data_q, st_data_d;
    logic        cop_we_q, cop_we_d, st_valid_q, st_valid_d, illegal_op_q, illegal_op_d;
    logic [15:0] issued_cnt_q, issued_cnt_d;

    fpu_inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (inst),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign inst_ready       = !fifo_full;
    assign push             = inst_valid && !fifo_full;
    assign cop_cache_done   = mem_stall;
    assign head_opc         = head[OPC_MSB:OPC_LSB];
    assign head_rs          = head[RS_MSB:RS_LSB];
    assign head_rt          = head[RT_MSB:RT_LSB];
    assign head_rd          = head[RD_MSB:RD_LSB];
    assign unused_head_bits = ^head[RD_LSB-1:0];

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        hold         = 1'b0;
        cop_opcode_d = OPC_NOP;
        cop_in1_d    = '0;
        cop_in2_d    = '0;
        cop_dst_d    = '0;
        cop_waddr_d  = '0;
        cop_wdata_d  = '0;
        cop_we_d     = 1'b0;
        ld_rt_d      = ld_rt_q;
        st_valid_d   = 1'b0;
        st_data_d    = st_data_q;
        illegal_op_d = 1'b0;
        issued_cnt_d = issued_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !mem_stall) begin
                    pop = 1'b1;
                    if (is_arith(head_opc)) begin
                        state_d      = S_ISSUE;
                        cop_opcode_d = head_opc;
                        cop_in1_d    = head_rs;
                        cop_in2_d    = head_rt;
                        cop_dst_d    = head_rd;
                    end else if (head_opc == OPC_LOAD) begin
                        state_d = S_LD_WAIT;
                        ld_rt_d = head_rt;
                    end else if (head_opc == OPC_STORE) begin
                        state_d      = S_ST_ISSUE;
                        cop_opcode_d = OPC_STORE;
                        cop_in2_d    = head_rt;
                    end else begin
                        illegal_op_d = 1'b1;
                    end
                end
            end
            S_ISSUE, S_LD_WR, S_ST_ISSUE: begin
                if (mem_stall) begin
                    hold = 1'b1;
                end else begin
                    issued_cnt_d = issued_cnt_q + 16'd1;
                    state_d      = (state_q == S_ST_ISSUE) ? S_ST_CAP : S_IDLE;
                end
            end
            S_LD_WAIT: begin
                if (ld_valid) begin
                    state_d     = S_LD_WR;
                    cop_we_d    = 1'b1;
                    cop_waddr_d = ld_rt_q;
                    cop_wdata_d = ld_data;
                end
            end
            S_ST_CAP: begin
                st_data_d  = cop_outdata;
                st_valid_d = 1'b1;
                state_d    = S_ST_HOLD;
            end
            S_ST_HOLD: begin
                if (st_ready) state_d    = S_IDLE;
                else          st_valid_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // A stalled issue cycle keeps every coprocessor output frozen.
        if (hold) begin
            cop_opcode_d = cop_opcode_q;
            cop_in1_d    = cop_in1_q;
            cop_in2_d    = cop_in2_q;
            cop_dst_d    = cop_dst_q;
            cop_waddr_d  = cop_waddr_q;
            cop_wdata_d  = cop_wdata_q;
            cop_we_d     = cop_we_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cop_opcode_q <= OPC_NOP;
            cop_in1_q    <= '0;
            cop_in2_q    <= '0;
            cop_dst_q    <= '0;
            cop_waddr_q  <= '0;
            cop_wdata_q  <= '0;
            cop_we_q     <= 1'b0;
            ld_rt_q      <= '0;
            st_valid_q   <= 1'b0;
            st_data_q    <= '0;
            illegal_op_q <= 1'b0;
            issued_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cop_opcode_q <= cop_opcode_d;
            cop_in1_q    <= cop_in1_d;
            cop_in2_q    <= cop_in2_d;
            cop_dst_q    <= cop_dst_d;
            cop_waddr_q  <= cop_waddr_d;
            cop_wdata_q  <= cop_wdata_d;
            cop_we_q     <= cop_we_d;
            ld_rt_q      <= ld_rt_d;
            st_valid_q   <= st_valid_d;
            st_data_q    <= st_data_d;
            illegal_op_q <= illegal_op_d;
            issued_cnt_q <= issued_cnt_d;
        end
    end

    assign cop_opcode = cop_opcode_q;
    assign cop_in1    = cop_in1_q;
    assign cop_in2    = cop_in2_q;
    assign cop_dst    = cop_dst_q;
    assign cop_waddr  = cop_waddr_q;
    assign cop_wdata  = cop_wdata_q;
    assign cop_we     = cop_we_q;
    assign st_valid   = st_valid_q;
    assign st_data    = st_data_q;
    assign illegal_op = illegal_op_q;
    assign issued_cnt = issued_cnt_q;

endmodule
`default_nettype wire
